morse_decoder: RTL
==================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 The block SHALL have parameter GAP_BITS, default 3, meaning the number of consecutive sampled 0 bits that terminates a letter (legal range 3..7).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 BitValid  input  1  single-cycle strobe, synchronous to clk; DotDash is sampled only on cycles where it is 1.
REQ-005 DotDash  input  1  serial Morse element stream: 1 = mark, 0 = space, one element per BitValid.
REQ-006 LetterOut  output  3  decoded letter code: A=000, B=001, ... H=111.
REQ-007 LetterValid  output  1  one-cycle pulse; LetterOut carries a newly decoded letter.
REQ-008 Error  output  1  one-cycle pulse; the terminated letter was malformed or unrecognised.
REQ-009 Busy  output  1  high while a letter is in progress (state MARK or SPACE).

Function
REQ-010 The block SHALL be a registered FSM with states IDLE, MARK and SPACE, plus these registers:
  - mark_cnt, 3 bits, saturating at 4
  - space_cnt, 3 bits
  - sym, a 4-entry symbol shift register (dot=0, dash=1, stored in arrival order)
  - sym_len, 3 bits
  - a sticky err flag
REQ-011 Cycles with BitValid=0 SHALL change no state or counter, and SHALL NOT assert LetterValid or Error.
REQ-012 IDLE: a sampled 0 SHALL be ignored; a sampled 1 SHALL go to MARK with mark_cnt=1, sym_len=0 and err=0.
REQ-013 MARK with a sampled 1: mark_cnt SHALL increment, saturating at 4.
REQ-014 MARK with a sampled 0: the mark SHALL be classified (mark_cnt=1 is a dot, mark_cnt=3 is a dash, anything else sets err), then the block SHALL go to SPACE with space_cnt=1.
REQ-015 A classified symbol SHALL be appended to sym and sym_len incremented; if sym_len is already 4, the symbol SHALL be dropped and err set.
REQ-016 SPACE with a sampled 1 and space_cnt=1: the block SHALL go to MARK with mark_cnt=1 (intra-letter gap).
REQ-017 SPACE with a sampled 1 and 1<space_cnt<GAP_BITS:
  - Error SHALL pulse.
  - sym, sym_len and err SHALL clear.
  - The block SHALL go to MARK with mark_cnt=1; this 1 starts a new letter.
REQ-018 SPACE with a sampled 0: space_cnt SHALL increment.
REQ-019 When space_cnt reaches GAP_BITS, the letter SHALL terminate: decode, go to IDLE, clear sym, sym_len and err.
REQ-020 Decode table: A=.-, B=-..., C=-.-., D=-.., E=., F=..-., G=--., H=....
REQ-021 On termination with err=0 and a table match, LetterOut SHALL update and LetterValid SHALL pulse.
REQ-022 On termination with err=1 or no table match, Error SHALL pulse and LetterOut SHALL hold its previous value.
REQ-023 LetterValid and Error SHALL be registered: asserted in the clk cycle after the terminating BitValid cycle, for exactly one cycle, and never both at once.
REQ-024 LetterOut SHALL hold its last decoded value until the next LetterValid.
REQ-025 Busy SHALL be registered and SHALL equal (state != IDLE).
REQ-026 The block SHALL accept BitValid on consecutive clk cycles and lose no bits.

Reset
REQ-027 While Reset=1, the block SHALL hold: state=IDLE, all counters, sym, sym_len and err = 0, LetterOut=000, LetterValid=0, Error=0, Busy=0.
REQ-028 Reset SHALL take effect asynchronously and dominate any simultaneous BitValid.
REQ-029 Assertion of Reset mid-letter SHALL discard the partial letter with no LetterValid or Error pulse.

Verification
REQ-030 Stream 1,0,1,1,1,0,0,0 (one bit per BitValid) -> LetterValid one cycle after the 8th strobe, LetterOut=000 (A).
REQ-031 Stream 1,0,1,0,1,0,1,0,0,0,0,0 -> a single LetterValid with LetterOut=111 (H); the trailing 4th and 5th zeros are ignored in IDLE.
REQ-032 Stream 1,1,0,0,0 (2-bit mark) -> Error pulse, no LetterValid, LetterOut unchanged.
REQ-033 Stream 1,0,0,1,0,0,0 (2-zero gap) -> Error pulse after the 4th strobe, then LetterValid with LetterOut=100 (E).
REQ-034 E then A back-to-back on consecutive-cycle BitValid -> two LetterValid pulses with LetterOut 100 then 000.
REQ-035 Reset asserted after 1,1,1,0 of B -> Busy=0 immediately; the following full B stream yields LetterOut=001.

Source files
------------

// File: rtl/morse_decoder.sv
// Serial Morse element decoder for letters A..H: classifies marks into dots and
// dashes, collects up to four symbols and decodes the letter after a GAP_BITS space.
module morse_decoder #(
    parameter int unsigned GAP_BITS = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       BitValid,
    input  logic       DotDash,
    output logic [2:0] LetterOut,
    output logic       LetterValid,
    output logic       Error,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE
    } state_t;

    localparam logic [2:0] GAP = 3'(GAP_BITS);

    state_t     state, state_n;
    logic [2:0] mark_cnt, mark_cnt_n;
    logic [2:0] space_cnt, space_cnt_n;
    logic [3:0] sym, sym_n;
    logic [2:0] sym_len, sym_len_n;
    logic       err, err_n;
    logic [2:0] letter_n;
    logic       lv_n, er_n;
    logic [2:0] dec_code;
    logic       dec_hit;
    logic [2:0] sc_inc;

    // sym holds the symbols oldest-first in its low sym_len bits (dot=0, dash=1)
    always_comb begin
        dec_hit  = 1'b1;
        dec_code = '0;
        case (sym_len)
            3'd1: if (sym[0] == 1'b0) dec_code = 3'd4; else dec_hit = 1'b0;
            3'd2: if (sym[1:0] == 2'b01) dec_code = 3'd0; else dec_hit = 1'b0;
            3'd3: begin
                case (sym[2:0])
                    3'b100:  dec_code = 3'd3;
                    3'b110:  dec_code = 3'd6;
                    default: dec_hit  = 1'b0;
                endcase
            end
            3'd4: begin
                case (sym)
                    4'b1000: dec_code = 3'd1;
                    4'b1010: dec_code = 3'd2;
                    4'b0010: dec_code = 3'd5;
                    4'b0000: dec_code = 3'd7;
                    default: dec_hit  = 1'b0;
                endcase
            end
            default: dec_hit = 1'b0;
        endcase
    end

    assign sc_inc = space_cnt + 3'd1;

    always_comb begin
        state_n     = state;
        mark_cnt_n  = mark_cnt;
        space_cnt_n = space_cnt;
        sym_n       = sym;
        sym_len_n   = sym_len;
        err_n       = err;
        letter_n    = LetterOut;
        lv_n        = 1'b0;
        er_n        = 1'b0;
        if (BitValid) begin
            case (state)
                IDLE: begin
                    if (DotDash) begin
                        state_n    = MARK;
                        mark_cnt_n = 3'd1;
                        sym_n      = '0;
                        sym_len_n  = '0;
                        err_n      = 1'b0;
                    end
                end
                MARK: begin
                    if (DotDash) begin
                        if (mark_cnt != 3'd4) mark_cnt_n = mark_cnt + 3'd1;
                    end else begin
                        if (mark_cnt == 3'd1 || mark_cnt == 3'd3) begin
                            if (sym_len == 3'd4) begin
                                err_n = 1'b1;
                            end else begin
                                sym_n     = {sym[2:0], (mark_cnt == 3'd3)};
                                sym_len_n = sym_len + 3'd1;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                        state_n     = SPACE;
                        space_cnt_n = 3'd1;
                    end
                end
                SPACE: begin
                    if (DotDash) begin
                        // a short-but-not-letter gap aborts the letter and this mark starts the next one
                        if (space_cnt != 3'd1) begin
                            er_n      = 1'b1;
                            sym_n     = '0;
                            sym_len_n = '0;
                            err_n     = 1'b0;
                        end
                        state_n    = MARK;
                        mark_cnt_n = 3'd1;
                    end else begin
                        space_cnt_n = sc_inc;
                        if (sc_inc == GAP) begin
                            if (!err && dec_hit) begin
                                lv_n     = 1'b1;
                                letter_n = dec_code;
                            end else begin
                                er_n = 1'b1;
                            end
                            state_n   = IDLE;
                            sym_n     = '0;
                            sym_len_n = '0;
                            err_n     = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            mark_cnt    <= '0;
            space_cnt   <= '0;
            sym         <= '0;
            sym_len     <= '0;
            err         <= 1'b0;
            LetterOut   <= '0;
            LetterValid <= 1'b0;
            Error       <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_n;
            mark_cnt    <= mark_cnt_n;
            space_cnt   <= space_cnt_n;
            sym         <= sym_n;
            sym_len     <= sym_len_n;
            err         <= err_n;
            LetterOut   <= letter_n;
            LetterValid <= lv_n;
            Error       <= er_n;
            Busy        <= (state_n != IDLE);
        end
    end

endmodule
